// File: rtl/rs_pe_row.sv
// Row-stationary PE row: holds P filter rows of S taps, slides an S-pixel window along
// an ifmap row and emits one psum per (column, filter), added to the neighbour's psum.
module rs_pe_row #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 16,
  parameter int S_MAX  = 8,
  parameter int P_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        S,
  input  logic [2:0]        P,
  input  logic [7:0]        W,
  input  logic              begin_layer,
  input  logic              flt_valid,
  output logic              flt_ready,
  input  logic [DATA_W-1:0] flt_data,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [DATA_W-1:0] if_data,
  input  logic              psum_in_valid,
  output logic              psum_in_ready,
  input  logic [ACC_W-1:0]  psum_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_psum,
  output logic              busy,
  output logic              PE_complete,
  output logic              cfg_err
);

  localparam int SIW = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int PIW = (P_MAX > 1) ? $clog2(P_MAX) : 1;
  localparam logic [3:0] S_MAX_L = 4'(S_MAX);
  localparam logic [2:0] P_MAX_L = 3'(P_MAX);

  typedef enum logic [2:0] {IDLE, LOAD_F, FILL, MAC, ACC, OUT, DONE} state_t;
  state_t state_reg, state_next;

  logic [3:0]        s_reg;
  logic [2:0]        p_lat_reg;
  logic [7:0]        w_reg;
  logic [3:0]        cnt_reg;
  logic [2:0]        p_reg;
  logic [7:0]        x_reg;
  logic              cfg_err_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [ACC_W-1:0]  out_psum_reg;
  logic [DATA_W-1:0] flt_reg [P_MAX][S_MAX];
  logic [DATA_W-1:0] win_reg [S_MAX];
  logic [DATA_W-1:0] win_next [S_MAX];

  logic cfg_ok, flt_xfer, if_xfer, psum_xfer, out_xfer;
  logic last_s, last_p, last_x, fill_done;
  logic [DATA_W-1:0] flt_cur, win_cur;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0] acc_base;

  assign cfg_ok = (S != 4'd0) && (S <= S_MAX_L) && (P != 3'd0) && (P <= P_MAX_L)
                  && (W >= {4'd0, S});

  assign flt_ready     = (state_reg == LOAD_F);
  assign if_ready      = (state_reg == FILL);
  assign psum_in_ready = (state_reg == ACC);
  assign out_valid     = (state_reg == OUT);
  assign busy          = (state_reg != IDLE);
  assign PE_complete   = (state_reg == DONE);
  assign cfg_err       = cfg_err_reg;
  assign out_psum      = out_psum_reg;

  assign flt_xfer  = flt_valid && flt_ready;
  assign if_xfer   = if_valid && if_ready;
  assign psum_xfer = psum_in_valid && psum_in_ready;
  assign out_xfer  = out_valid && out_ready;

  assign last_s    = (cnt_reg == s_reg - 4'd1);
  assign last_p    = (p_reg == p_lat_reg - 3'd1);
  assign last_x    = (x_reg == w_reg - {4'd0, s_reg});
  // The first window needs S pixels; every later window slides in a single pixel.
  assign fill_done = if_xfer && ((x_reg != 8'd0) || last_s);

  assign flt_cur  = flt_reg[p_reg[PIW-1:0]][cnt_reg[SIW-1:0]];
  assign win_cur  = win_reg[cnt_reg[SIW-1:0]];
  assign prod     = (2*DATA_W)'($signed(flt_cur)) * (2*DATA_W)'($signed(win_cur));
  assign acc_base = (cnt_reg == 4'd0) ? '0 : acc_reg;

  // Window entry 0 is the oldest pixel; new pixels enter at S-1.
  for (genvar gi = 0; gi < S_MAX; gi++) begin : g_win
    if (gi < S_MAX - 1) begin : g_shift
      assign win_next[gi] = (4'(gi) == s_reg - 4'd1) ? if_data : win_reg[gi+1];
    end else begin : g_top
      assign win_next[gi] = if_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (begin_layer && cfg_ok) state_next = LOAD_F;
      LOAD_F:  if (flt_xfer && last_s && last_p) state_next = FILL;
      FILL:    if (fill_done) state_next = MAC;
      MAC:     if (last_s) state_next = ACC;
      ACC:     if (psum_xfer) state_next = OUT;
      OUT: begin
        if (out_xfer) begin
          if (!last_p)      state_next = MAC;
          else if (!last_x) state_next = FILL;
          else              state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_reg        <= '0;
      p_lat_reg    <= '0;
      w_reg        <= '0;
      cnt_reg      <= '0;
      p_reg        <= '0;
      x_reg        <= '0;
      cfg_err_reg  <= 1'b0;
      acc_reg      <= '0;
      out_psum_reg <= '0;
      for (int i = 0; i < P_MAX; i++)
        for (int j = 0; j < S_MAX; j++)
          flt_reg[i][j] <= '0;
      for (int j = 0; j < S_MAX; j++)
        win_reg[j] <= '0;
    end else begin
      if (if_xfer)
        for (int j = 0; j < S_MAX; j++)
          win_reg[j] <= win_next[j];
      case (state_reg)
        IDLE: begin
          if (begin_layer) begin
            if (cfg_ok) begin
              s_reg       <= S;
              p_lat_reg   <= P;
              w_reg       <= W;
              cnt_reg     <= '0;
              p_reg       <= '0;
              x_reg       <= '0;
              cfg_err_reg <= 1'b0;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end
        end
        LOAD_F: begin
          if (flt_xfer) begin
            flt_reg[p_reg[PIW-1:0]][cnt_reg[SIW-1:0]] <= flt_data;
            if (last_s) begin
              cnt_reg <= '0;
              p_reg   <= last_p ? 3'd0 : p_reg + 3'd1;
            end else begin
              cnt_reg <= cnt_reg + 4'd1;
            end
          end
        end
        FILL: begin
          if (if_xfer) cnt_reg <= fill_done ? 4'd0 : cnt_reg + 4'd1;
        end
        MAC: begin
          acc_reg <= acc_base + ACC_W'(prod);
          cnt_reg <= last_s ? 4'd0 : cnt_reg + 4'd1;
        end
        ACC: begin
          if (psum_xfer) out_psum_reg <= acc_reg + psum_in;
        end
        OUT: begin
          if (out_xfer) begin
            if (!last_p) begin
              p_reg <= p_reg + 3'd1;
            end else begin
              p_reg <= '0;
              if (!last_x) x_reg <= x_reg + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_pe_row.sv
// Self-checking bench for rs_pe_row: directed vectors plus randomized layers checked
// against an arithmetic convolution model.
module tb_rs_pe_row;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  S;
  logic [2:0]  P;
  logic [7:0]  W;
  logic        begin_layer;
  logic        flt_valid, flt_ready;
  logic [15:0] flt_data;
  logic        if_valid, if_ready;
  logic [15:0] if_data;
  logic        psum_in_valid, psum_in_ready;
  logic [15:0] psum_in;
  logic        out_valid, out_ready;
  logic [15:0] out_psum;
  logic        busy, PE_complete, cfg_err;

  rs_pe_row dut (
    .clk(clk), .rst(rst), .S(S), .P(P), .W(W), .begin_layer(begin_layer),
    .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_data(flt_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_data(if_data),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
    .busy(busy), .PE_complete(PE_complete), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] flt_mem [32];
  logic [15:0] ifm_mem [256];
  logic [15:0] pin_mem [1024];
  logic [15:0] got [$];
  logic [15:0] exp_q [$];
  int   pe_pulses, unstable, timed_out, first_lat, aborted, mode, abort_mid;
  logic err_after_begin;

  task automatic load_spec(input int nflt, input logic [15:0] pin_val);
    logic [15:0] f [6];
    f = '{16'd1, 16'd2, 16'd3, 16'd1, 16'd0, 16'hFFFF};
    for (int i = 0; i < nflt; i++) flt_mem[i] = f[i];
    for (int i = 0; i < 5; i++) ifm_mem[i] = 16'(i + 1);
    for (int i = 0; i < 1024; i++) pin_mem[i] = pin_val;
  endtask

  // Direct convolution of the stored streams, x-major / p-minor.
  task automatic build_expected(input int s, input int p, input int w);
    longint sum;
    int k;
    exp_q.delete();
    k = 0;
    for (int x = 0; x <= w - s; x++)
      for (int pp = 0; pp < p; pp++) begin
        sum = 0;
        for (int ss = 0; ss < s; ss++)
          sum += longint'($signed(flt_mem[pp*s+ss])) * longint'($signed(ifm_mem[x+ss]));
        sum += longint'(pin_mem[k]);
        exp_q.push_back(16'(sum));
        k++;
      end
  endtask

  task automatic run_layer(input logic [3:0] s, input logic [2:0] p, input logic [7:0] w);
    int fi, ii, pi, it, mac_it, acc_hold, out_hold, tail, nf, ni, np;
    logic ftx, itx, ptx, otx, holding;
    logic [15:0] held, oval;
    fi = 0; ii = 0; pi = 0; it = 0; mac_it = 0; acc_hold = 0; out_hold = 0; tail = -1;
    holding = 1'b0; held = '0;
    nf = int'(p) * int'(s); ni = int'(w); np = (int'(w) - int'(s) + 1) * int'(p);
    got.delete(); pe_pulses = 0; unstable = 0; timed_out = 0; first_lat = -1; aborted = 0;
    @(negedge clk); S = s; P = p; W = w; begin_layer = 1'b1;
    @(negedge clk); begin_layer = 1'b0; err_after_begin = cfg_err;
    while (1) begin
      flt_valid = (fi < nf) && (mode != 1 || $urandom_range(0, 3) != 0);
      flt_data  = (fi < nf) ? flt_mem[fi] : 16'($urandom);
      if_valid  = (ii < ni) && (mode != 1 || $urandom_range(0, 3) != 0);
      if_data   = (ii < ni) ? ifm_mem[ii] : 16'($urandom);
      if (mode == 2 && psum_in_ready && acc_hold < 3) begin
        psum_in_valid = 1'b0; acc_hold++;
      end else begin
        psum_in_valid = (pi < np) && (mode != 1 || $urandom_range(0, 3) != 0);
      end
      psum_in = (pi < np) ? pin_mem[pi] : 16'($urandom);
      if (mode == 2 && out_valid && out_hold < 5) begin
        out_ready = 1'b0; out_hold++;
      end else begin
        out_ready = (mode != 1) || ($urandom_range(0, 2) != 0);
      end
      if (PE_complete) pe_pulses++;
      if (out_valid && first_lat < 0) first_lat = it - mac_it + 1;
      if (holding && (!out_valid || out_psum !== held)) unstable++;
      holding = out_valid && !out_ready;
      held = out_psum;
      ftx = flt_valid && flt_ready; itx = if_valid && if_ready;
      ptx = psum_in_valid && psum_in_ready; otx = out_valid && out_ready;
      oval = out_psum;
      @(posedge clk);
      if (ftx) fi++;
      if (itx) begin ii++; mac_it = it + 1; end
      if (ptx) begin pi++; acc_hold = 0; end
      if (otx) begin got.push_back(oval); out_hold = 0; end
      it++;
      if (abort_mid != 0 && itx && got.size() > 0) begin aborted = 1; break; end
      if (pe_pulses > 0 && tail < 0) tail = 3;
      if (tail > 0) tail--;
      if (tail == 0) break;
      if (it > 4000) begin timed_out = 1; break; end
      @(negedge clk);
    end
    flt_valid = 1'b0; if_valid = 1'b0; psum_in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; begin_layer = 1'b0; S = '0; P = '0; W = '0;
    flt_valid = 1'b0; flt_data = '0; if_valid = 1'b0; if_data = '0;
    psum_in_valid = 1'b0; psum_in = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_psum !== 16'd0) begin n_err++; $display("FAIL reset_out_psum: got %h expected 0000", out_psum); end
    n_cmp++; if ({out_valid, flt_ready, if_ready, psum_in_ready} !== 4'b0) begin n_err++; $display("FAIL reset_handshake: got %b expected 0000", {out_valid, flt_ready, if_ready, psum_in_ready}); end
    n_cmp++; if ({busy, PE_complete, cfg_err} !== 3'b0) begin n_err++; $display("FAIL reset_status: got %b expected 000", {busy, PE_complete, cfg_err}); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_stay_idle: busy got %b expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_spec_vectors();
    logic [15:0] e1 [3];
    logic [15:0] e2 [6];
    logic [15:0] e3 [6];
    e1 = '{16'd14, 16'd20, 16'd26};
    e2 = '{16'd14, 16'hFFFE, 16'd20, 16'hFFFE, 16'd26, 16'hFFFE};
    e3 = '{16'd114, 16'd98, 16'd120, 16'd98, 16'd126, 16'd98};
    mode = 0;
    load_spec(3, 16'd0);
    run_layer(4'd3, 3'd1, 8'd5);
    n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL p1_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== e1[i]) begin n_err++; $display("FAIL p1_psum[%0d]: got %h expected %h", i, got[i], e1[i]); end
    end
    n_cmp++; if (pe_pulses != 1) begin n_err++; $display("FAIL p1_complete: got %0d pulses expected 1", pe_pulses); end
    n_cmp++; if (first_lat != 5) begin n_err++; $display("FAIL p1_latency: got %0d expected 5", first_lat); end
    n_cmp++; if (timed_out != 0) begin n_err++; $display("FAIL p1_timeout: got %0d expected 0", timed_out); end
    $display("spec P=1 outputs=%0d", got.size());
    load_spec(6, 16'd0);
    run_layer(4'd3, 3'd2, 8'd5);
    n_cmp++; if (got.size() != 6) begin n_err++; $display("FAIL p2_count: got %0d expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== e2[i]) begin n_err++; $display("FAIL p2_psum[%0d]: got %h expected %h", i, got[i], e2[i]); end
    end
    $display("spec P=2 psum_in=0 outputs=%0d", got.size());
    load_spec(6, 16'd100);
    run_layer(4'd3, 3'd2, 8'd5);
    n_cmp++; if (got.size() != 6) begin n_err++; $display("FAIL p2b_count: got %0d expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== e3[i]) begin n_err++; $display("FAIL p2b_psum[%0d]: got %h expected %h", i, got[i], e3[i]); end
    end
    $display("spec P=2 psum_in=100 outputs=%0d", got.size());
  endtask

  task automatic test_back_to_back_stall();
    logic [15:0] e3 [6];
    e3 = '{16'd114, 16'd98, 16'd120, 16'd98, 16'd126, 16'd98};
    mode = 2;
    load_spec(6, 16'd100);
    run_layer(4'd3, 3'd2, 8'd5);
    n_cmp++; if (got.size() != 6) begin n_err++; $display("FAIL stall_count: got %0d expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== e3[i]) begin n_err++; $display("FAIL stall_psum[%0d]: got %h expected %h", i, got[i], e3[i]); end
    end
    n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL stall_stable: got %0d changes expected 0", unstable); end
    n_cmp++; if (pe_pulses != 1) begin n_err++; $display("FAIL stall_complete: got %0d pulses expected 1", pe_pulses); end
    mode = 0;
    $display("stall run outputs=%0d", got.size());
  endtask

  task automatic test_cfg_err();
    logic saw_flt;
    saw_flt = 1'b0;
    @(negedge clk); S = 4'd0; P = 3'd1; W = 8'd5; begin_layer = 1'b1;
    @(negedge clk); begin_layer = 1'b0;
    n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_s0_err: got %b expected 1", cfg_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cfg_s0_busy: got %b expected 0", busy); end
    repeat (3) begin @(negedge clk); if (flt_ready) saw_flt = 1'b1; end
    S = 4'd3; P = 3'd1; W = 8'd2; begin_layer = 1'b1;
    @(negedge clk); begin_layer = 1'b0;
    n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_w_err: got %b expected 1", cfg_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cfg_w_busy: got %b expected 0", busy); end
    repeat (3) begin @(negedge clk); if (flt_ready) saw_flt = 1'b1; end
    n_cmp++; if (saw_flt !== 1'b0) begin n_err++; $display("FAIL cfg_flt_ready: got %b expected 0", saw_flt); end
    mode = 0;
    load_spec(3, 16'd0);
    run_layer(4'd3, 3'd1, 8'd5);
    n_cmp++; if (err_after_begin !== 1'b0) begin n_err++; $display("FAIL cfg_clear: got %b expected 0", err_after_begin); end
    n_cmp++; if (got.size() != 3 || got[2] !== 16'd26) begin n_err++; $display("FAIL cfg_legal_run: got %0d outputs expected 3 ending 001a", got.size()); end
    $display("cfg_err test done");
  endtask

  task automatic test_reset_mid();
    logic [15:0] e1 [3];
    e1 = '{16'd14, 16'd20, 16'd26};
    mode = 0; abort_mid = 1;
    load_spec(3, 16'd0);
    run_layer(4'd3, 3'd1, 8'd5);
    abort_mid = 0;
    n_cmp++; if (aborted != 1) begin n_err++; $display("FAIL mid_reach_mac: got %0d expected 1", aborted); end
    n_cmp++; if (out_psum !== 16'd14) begin n_err++; $display("FAIL mid_pre_psum: got %h expected 000e", out_psum); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (out_psum !== 16'd0) begin n_err++; $display("FAIL mid_rst_psum: got %h expected 0000", out_psum); end
    n_cmp++; if ({out_valid, flt_ready, if_ready, psum_in_ready, busy, PE_complete, cfg_err} !== 7'b0) begin
      n_err++; $display("FAIL mid_rst_flags: got %b expected 0000000", {out_valid, flt_ready, if_ready, psum_in_ready, busy, PE_complete, cfg_err});
    end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_post_idle: busy got %b expected 0", busy); end
    run_layer(4'd3, 3'd1, 8'd5);
    n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL mid_rerun_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== e1[i]) begin n_err++; $display("FAIL mid_rerun[%0d]: got %h expected %h", i, got[i], e1[i]); end
    end
    $display("mid-MAC reset test done");
  endtask

  task automatic test_wrap();
    mode = 0;
    for (int i = 0; i < 8; i++) begin flt_mem[i] = 16'h7FFF; ifm_mem[i] = 16'h7FFF; end
    for (int i = 0; i < 4; i++) pin_mem[i] = 16'd0;
    run_layer(4'd8, 3'd1, 8'd8);
    n_cmp++; if (got.size() != 1 || got[0] !== 16'h0008) begin
      n_err++; $display("FAIL wrap_psum: got %0d outputs first %h expected 1 output 0008", got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
    end
    n_cmp++; if (first_lat != 10) begin n_err++; $display("FAIL wrap_latency: got %0d expected 10", first_lat); end
    $display("wrap test outputs=%0d", got.size());
  endtask

  task automatic test_random();
    int s, p, w;
    mode = 1;
    for (int t = 0; t < 8; t++) begin
      s = $urandom_range(1, 8); p = $urandom_range(1, 4); w = s + $urandom_range(0, 4);
      for (int i = 0; i < 32; i++) flt_mem[i] = 16'($urandom);
      for (int i = 0; i < 256; i++) ifm_mem[i] = 16'($urandom);
      for (int i = 0; i < 64; i++) pin_mem[i] = 16'($urandom);
      build_expected(s, p, w);
      run_layer(4'(s), 3'(p), 8'(w));
      n_cmp++; if (got.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_count: got %0d expected %0d", t, got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_psum[%0d]: got %h expected %h", t, i, got[i], exp_q[i]); end
      end
      n_cmp++; if (unstable != 0 || pe_pulses != 1) begin n_err++; $display("FAIL rand%0d_proto: got %0d unstable %0d pulses expected 0 and 1", t, unstable, pe_pulses); end
      $display("random layer %0d S=%0d P=%0d W=%0d outputs=%0d", t, s, p, w, got.size());
    end
    mode = 0;
  endtask

  initial begin
    mode = 0; abort_mid = 0;
    test_reset();
    test_spec_vectors();
    test_back_to_back_stall();
    test_cfg_err();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rs_pe_row.md
RS_PE_ROW -- requirements
Module: rs_pe_row

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the width of the filter and ifmap words.
REQ-002 The block SHALL have parameter ACC_W, default 16, giving the width of psums; arithmetic wraps modulo 2^ACC_W.
REQ-003 The block SHALL have parameter S_MAX, default 8, giving the maximum filter row length.
REQ-004 The block SHALL have parameter P_MAX, default 4, giving the maximum number of interleaved filters.

Interface
REQ-005 The block SHALL have these ports, one per line:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- S  input  4  filter row length, sampled at begin_layer.
- P  input  3  number of filters, sampled at begin_layer.
- W  input  8  ifmap row length, sampled at begin_layer.
- begin_layer  input  1  start pulse.
- flt_valid / flt_ready / flt_data  in / out / in  1/1/DATA_W  filter load stream.
- if_valid / if_ready / if_data  in / out / in  1/1/DATA_W  ifmap pixel stream.
- psum_in_valid / psum_in_ready / psum_in  in / out / in  1/1/ACC_W  incoming psum from the neighbour PE.
- out_valid / out_ready / out_psum  out / in / out  1/1/ACC_W  outgoing psum.
- busy  output  1  high in every state except IDLE.
- PE_complete  output  1  one-cycle pulse on entry to DONE.
- cfg_err  output  1  sticky error flag; cleared by the next accepted begin_layer.

Function
REQ-006 A transfer SHALL occur on any stream only in a cycle where its valid and ready are both high at the rising edge.
REQ-007 The FSM SHALL have the states IDLE, LOAD_F, FILL, MAC, ACC, OUT and DONE.
REQ-008 In IDLE, begin_layer=1 with 1<=S<=S_MAX, 1<=P<=P_MAX and W>=S SHALL latch S/P/W, clear cfg_err and go to LOAD_F.
REQ-009 In IDLE, begin_layer=1 with an illegal config SHALL set cfg_err=1 and keep the FSM in IDLE.
REQ-010 begin_layer SHALL be ignored in every state other than IDLE.
REQ-011 In LOAD_F, flt_ready=1 and the FSM SHALL accept P*S words in order filter[p][s], s fastest, then go to FILL.
REQ-012 In FILL, if_ready=1 and accepted pixels SHALL shift into an S-deep window; after S pixels (first window) or 1 pixel (later windows) the FSM SHALL go to MAC with p=0.
REQ-013 MAC SHALL take exactly S cycles, one signed multiply-accumulate per cycle: acc = sum over s of filter[p][s]*window[s], truncated to ACC_W.
REQ-014 In ACC, psum_in_ready=1; on transfer the block SHALL register out_psum = acc + psum_in and go to OUT on the next cycle.
REQ-015 In OUT, out_valid=1 and out_psum SHALL be held stable until the transfer completes.
REQ-016 After the OUT transfer:
- if p<P-1: p increments and the FSM returns to MAC on the same window;
- else, if column x<W-S: x increments and the FSM returns to FILL;
- else: the FSM goes to DONE.
REQ-017 Output order SHALL be x-major, p-minor (W-S+1)*P psums; psum_in SHALL be consumed in the same order.
REQ-018 DONE SHALL last one cycle, pulse PE_complete, and return to IDLE.
REQ-019 Each ready signal SHALL be high only in its own state; all readys are low in the other states.
REQ-020 Minimum per-output latency SHALL be S+2 cycles from MAC entry to out_valid; each stalled handshake adds cycles 1:1.
REQ-021 Filter registers SHALL persist across layers until reset or the next LOAD_F.

Reset
REQ-022 rst=0 SHALL immediately force the FSM to IDLE from any state, including mid-MAC or mid-OUT.
REQ-023 rst=0 SHALL clear the filter registers, window, acc, x and p.
REQ-024 rst=0 SHALL force out_psum=0 and out_valid, all readys, busy, PE_complete and cfg_err low.
REQ-025 After rst returns high, the block SHALL stay in IDLE until the next begin_layer.

Verification
REQ-026 S=3, P=1, W=5, filter {1,2,3}, ifmap {1,2,3,4,5}, psum_in=0 -> out_psum 14, 20, 26, then a single PE_complete pulse.
REQ-027 As REQ-026 with P=2 and second filter {1,0,0xFFFF} -> 14, 0xFFFE, 20, 0xFFFE, 26, 0xFFFE; with psum_in=100 on every transfer -> 114, 98, 120, 98, 126, 98.
REQ-028 out_ready held low for 5 cycles during OUT, and psum_in_valid low for 3 cycles during ACC -> out_psum stable, no extra or lost outputs, same result values.
REQ-029 begin_layer with S=0, then with W=2 and S=3 -> cfg_err=1, busy=0, flt_ready never high; a following legal begin_layer clears cfg_err.
REQ-030 rst asserted during MAC of the second column -> all outputs zero immediately; a rerun of REQ-026 after release gives correct results.
REQ-031 filter all 0x7FFF, ifmap all 0x7FFF, S=8 -> out_psum equals the 16-bit wrapped sum of 8*0x3FFF0001 = 0x0008.
